// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: walks output rows, column stages and kernel taps, issuing one
// vectorgen POP/SHIFT per tap. Define SEQ_PERF_CNT_EN to add the stall_cycles counter.
module conv_window_sequencer #(
    parameter int IMAGE_WIDTH   = 10,
    parameter int IMAGE_HEIGHT  = 10,
    parameter int NUM_PE        = 4,
    parameter int KERNEL_WIDTH  = 3,
    parameter int KERNEL_HEIGHT = 3,
    localparam int STAGES       = (IMAGE_WIDTH - KERNEL_WIDTH + NUM_PE) / NUM_PE,
    localparam int OUT_ROWS     = IMAGE_HEIGHT - KERNEL_HEIGHT + 1,
    localparam int TAPS         = KERNEL_WIDTH * KERNEL_HEIGHT,
    localparam int WA_W         = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            vectorgen_ready,
    input  logic            outbuf_ready,
    output logic            vectorgen_pop,
    output logic            vectorgen_shift,
    output logic            vectorgen_nextrow,
    output logic            pe_valid,
    output logic [WA_W-1:0] wgt_addr,
    output logic            busy,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]     stall_cycles,
`endif
    output logic            done
);

    localparam int KW_W = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1;
    localparam int KH_W = (KERNEL_HEIGHT > 1) ? $clog2(KERNEL_HEIGHT) : 1;
    localparam int ST_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int RW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

    localparam logic [KW_W-1:0] KwLast = KW_W'(KERNEL_WIDTH - 1);
    localparam logic [KH_W-1:0] KhLast = KH_W'(KERNEL_HEIGHT - 1);
    localparam logic [ST_W-1:0] StLast = ST_W'(STAGES - 1);
    localparam logic [RW_W-1:0] RwLast = RW_W'(OUT_ROWS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [KW_W-1:0] kw_q, kw_d;
    logic [KH_W-1:0] kh_q, kh_d;
    logic [ST_W-1:0] stage_q, stage_d;
    logic [RW_W-1:0] row_q, row_d;
    logic [WA_W-1:0] wgt_addr_q, wgt_addr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]     stall_q, stall_d;
`endif

    logic            issue;
    logic            last_kw, last_kh, last_stage, last_row;
    logic [WA_W-1:0] cur_addr;

    assign issue      = (state_q == StRun) && vectorgen_ready && outbuf_ready;
    assign last_kw    = (kw_q == KwLast);
    assign last_kh    = (kh_q == KhLast);
    assign last_stage = (stage_q == StLast);
    assign last_row   = (row_q == RwLast);
    assign cur_addr   = WA_W'(32'(kh_q) * KERNEL_WIDTH + 32'(kw_q));

    always_comb begin
        state_d    = state_q;
        kw_d       = kw_q;
        kh_d       = kh_q;
        stage_d    = stage_q;
        row_d      = row_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wgt_addr_d = issue ? cur_addr : wgt_addr_q;
`ifdef SEQ_PERF_CNT_EN
        stall_d    = stall_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    busy_d  = 1'b1;
`ifdef SEQ_PERF_CNT_EN
                    stall_d = '0;
`endif
                end
            end
            StRun: begin
                if (issue) begin
                    // Odometer: each counter wraps and carries into the next outer one.
                    kw_d = last_kw ? '0 : kw_q + KW_W'(1);
                    if (last_kw) begin
                        kh_d = last_kh ? '0 : kh_q + KH_W'(1);
                        if (last_kh) begin
                            stage_d = last_stage ? '0 : stage_q + ST_W'(1);
                            if (last_stage) begin
                                row_d = last_row ? '0 : row_q + RW_W'(1);
                                if (last_row) begin
                                    state_d = StDone;
                                    busy_d  = 1'b0;
                                    done_d  = 1'b1;
                                end
                            end
                        end
                    end
                end
`ifdef SEQ_PERF_CNT_EN
                else if (stall_q != 32'hFFFF_FFFF) begin
                    stall_d = stall_q + 32'd1;
                end
`endif
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            kw_q       <= '0;
            kh_q       <= '0;
            stage_q    <= '0;
            row_q      <= '0;
            wgt_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SEQ_PERF_CNT_EN
            stall_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            kw_q       <= kw_d;
            kh_q       <= kh_d;
            stage_q    <= stage_d;
            row_q      <= row_d;
            wgt_addr_q <= wgt_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SEQ_PERF_CNT_EN
            stall_q    <= stall_d;
`endif
        end
    end

    assign pe_valid          = issue;
    assign vectorgen_pop     = issue && (kw_q == '0);
    assign vectorgen_shift   = issue && (kw_q != '0);
    assign vectorgen_nextrow = issue && last_kw && last_kh && last_stage;
    assign wgt_addr          = wgt_addr_d;
    assign busy              = busy_q;
    assign done              = done_q;
`ifdef SEQ_PERF_CNT_EN
    assign stall_cycles      = stall_q;
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer: randomized readies against a tap-list model.
// A second instance built with KERNEL_WIDTH=1 checks that shift never asserts.
module tb_conv_window_sequencer;

    localparam int IW = 10, IH = 10, NP = 4, KW = 3, KH = 3;
    localparam int NSTAGE = (IW - KW + NP) / NP;
    localparam int NROW   = IH - KH + 1;
    localparam int TOTAL  = NROW * NSTAGE * KW * KH;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       vectorgen_ready = 1'b0;
    logic       outbuf_ready = 1'b0;
    logic       vectorgen_pop, vectorgen_shift, vectorgen_nextrow, pe_valid, busy, done;
    logic [3:0] wgt_addr;
    logic       k1_pop, k1_shift, k1_nextrow, k1_valid, k1_busy, k1_done;
    logic [1:0] k1_addr;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] stall_cycles, k1_stall;
`endif

    always #5 clk = ~clk;

    conv_window_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .vectorgen_ready(vectorgen_ready), .outbuf_ready(outbuf_ready),
        .vectorgen_pop(vectorgen_pop), .vectorgen_shift(vectorgen_shift),
        .vectorgen_nextrow(vectorgen_nextrow), .pe_valid(pe_valid),
        .wgt_addr(wgt_addr), .busy(busy),
`ifdef SEQ_PERF_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .done(done)
    );

    conv_window_sequencer #(.KERNEL_WIDTH(1)) dut_k1 (
        .clk(clk), .reset(reset), .start(start),
        .vectorgen_ready(vectorgen_ready), .outbuf_ready(outbuf_ready),
        .vectorgen_pop(k1_pop), .vectorgen_shift(k1_shift),
        .vectorgen_nextrow(k1_nextrow), .pe_valid(k1_valid),
        .wgt_addr(k1_addr), .busy(k1_busy),
`ifdef SEQ_PERF_CNT_EN
        .stall_cycles(k1_stall),
`endif
        .done(k1_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference tap list, built straight from the loop nest.
    int exp_addr [TOTAL];
    bit exp_pop  [TOTAL];
    bit exp_nr   [TOTAL];
    int m_addr = 0;

    int k1_valid_cnt = 0, k1_pop_cnt = 0, k1_shift_cnt = 0;

    always begin
        @(negedge clk);
        #2;
        if (k1_valid === 1'b1) k1_valid_cnt++;
        if (k1_pop === 1'b1) k1_pop_cnt++;
        if (k1_shift === 1'b1) k1_shift_cnt++;
    end

    task automatic build_model();
        int t = 0;
        for (int r = 0; r < NROW; r++)
            for (int s = 0; s < NSTAGE; s++)
                for (int h = 0; h < KH; h++)
                    for (int w = 0; w < KW; w++) begin
                        exp_addr[t] = h * KW + w;
                        exp_pop[t]  = (w == 0);
                        exp_nr[t]   = (w == KW - 1) && (h == KH - 1) && (s == NSTAGE - 1);
                        t++;
                    end
    endtask

    // One layer pass; every cycle is compared against the tap list.
    task automatic run_pass(input int rmode, input int abort_at, input bit repulse,
                            input int stall_tap, output int cv, output int cp,
                            output int cs, output int cn);
        int  tap = 0, stall_left = 5, exp_stall = 0;
        bit  last_issued = 0, seen_done = 0, exp_v;
        cv = 0; cp = 0; cs = 0; cn = 0;
        @(negedge clk);
        start = 1'b1; vectorgen_ready = 1'b1; outbuf_ready = 1'b1;
        #1;
        n_tests++;
        if (pe_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_cycle: pe_valid=%b busy=%b, required 0 0", pe_valid, busy);
        end
        for (int c = 1; c < 3000 && !seen_done; c++) begin
            @(negedge clk);
            start = repulse && (c == 20 || c == 21 || last_issued);
            vectorgen_ready = 1'b1; outbuf_ready = 1'b1;
            if (rmode == 1) begin
                vectorgen_ready = ($urandom_range(0, 3) != 0);
                outbuf_ready    = 1'($urandom_range(0, 1));
            end
            if (tap == stall_tap && stall_left > 0) begin
                vectorgen_ready = 1'b0;
                stall_left--;
            end
            if (tap == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                #1;
                n_tests++;
                if ({pe_valid, vectorgen_pop, vectorgen_shift, vectorgen_nextrow, busy, done}
                    !== 6'b0 || wgt_addr !== 4'd0) begin
                    n_fail++;
                    $display("FAIL reset_mid: valid/pop/shift/nr/busy/done=%b%b%b%b%b%b addr=%0d, required all 0",
                             pe_valid, vectorgen_pop, vectorgen_shift, vectorgen_nextrow,
                             busy, done, wgt_addr);
                end
                m_addr = 0;
                return;
            end
            #1;
            exp_v = vectorgen_ready && outbuf_ready && (tap < TOTAL);
            n_tests++;
            if (done !== last_issued || busy !== !last_issued) begin
                n_fail++;
                $display("FAIL done_busy c=%0d: done=%b busy=%b, required %b %b",
                         c, done, busy, last_issued, !last_issued);
            end
            if (last_issued) begin
                seen_done = 1;
                if (rmode == 0 && stall_tap < 0) begin
                    n_tests++;
                    if (c != 145) begin
                        n_fail++;
                        $display("FAIL done_latency: done at %0d, required 145", c);
                    end
                end
`ifdef SEQ_PERF_CNT_EN
                n_tests++;
                if (stall_cycles !== exp_stall) begin
                    n_fail++;
                    $display("FAIL stall_cycles: got %0d, required %0d", stall_cycles, exp_stall);
                end
`endif
            end
            n_tests++;
            if (pe_valid !== exp_v) begin
                n_fail++;
                $display("FAIL pe_valid tap=%0d c=%0d: got %b, required %b", tap, c, pe_valid, exp_v);
            end else if (exp_v) begin
                n_tests++;
                if (wgt_addr !== 4'(exp_addr[tap]) || vectorgen_pop !== exp_pop[tap] ||
                    vectorgen_shift !== !exp_pop[tap] || vectorgen_nextrow !== exp_nr[tap]) begin
                    n_fail++;
                    $display("FAIL tap %0d: addr=%0d pop=%b shift=%b nr=%b, required %0d %b %b %b",
                             tap, wgt_addr, vectorgen_pop, vectorgen_shift, vectorgen_nextrow,
                             exp_addr[tap], exp_pop[tap], !exp_pop[tap], exp_nr[tap]);
                end
                cv++;
                if (vectorgen_pop === 1'b1) cp++;
                if (vectorgen_shift === 1'b1) cs++;
                if (vectorgen_nextrow === 1'b1) cn++;
                m_addr = exp_addr[tap];
                tap++;
                if (tap == TOTAL) last_issued = 1;
            end else begin
                if (!last_issued) exp_stall++;
                n_tests++;
                if (vectorgen_pop !== 1'b0 || vectorgen_shift !== 1'b0 ||
                    vectorgen_nextrow !== 1'b0 || wgt_addr !== 4'(m_addr)) begin
                    n_fail++;
                    $display("FAIL idle_cycle c=%0d: pop=%b shift=%b nr=%b addr=%0d, required 0 0 0 %0d",
                             c, vectorgen_pop, vectorgen_shift, vectorgen_nextrow, wgt_addr, m_addr);
                end
            end
        end
        n_tests++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL timeout: done not seen, taps=%0d, required %0d", tap, TOTAL);
        end
        if (repulse) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            n_tests++;
            if (busy !== 1'b0 || pe_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL start_in_done: busy=%b pe_valid=%b, required 0 0", busy, pe_valid);
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_counts(input string name, input int cv, input int cp,
                                input int cs, input int cn);
        n_tests++;
        if (cv != TOTAL || cp != TOTAL / KW || cs != TOTAL - TOTAL / KW || cn != NROW) begin
            n_fail++;
            $display("FAIL %s counts: valid=%0d pop=%0d shift=%0d nr=%0d, required %0d %0d %0d %0d",
                     name, cv, cp, cs, cn, TOTAL, TOTAL / KW, TOTAL - TOTAL / KW, NROW);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        vectorgen_ready = 1'b1; outbuf_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        #1;
        n_tests++;
        if ({pe_valid, vectorgen_pop, vectorgen_shift, vectorgen_nextrow, busy, done} !== 6'b0 ||
            wgt_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: outputs=%b%b%b%b%b%b addr=%0d, required all 0",
                     pe_valid, vectorgen_pop, vectorgen_shift, vectorgen_nextrow, busy, done,
                     wgt_addr);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || pe_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wins: busy=%b pe_valid=%b, required 0 0", busy, pe_valid);
        end
    endtask

    task automatic test_full_pass();
        int cv, cp, cs, cn, k1_before;
        k1_before = k1_valid_cnt;
        run_pass(0, -1, 0, -1, cv, cp, cs, cn);
        check_counts("full_pass", cv, cp, cs, cn);
        n_tests++;
        if (k1_valid_cnt - k1_before != 72) begin
            n_fail++;
            $display("FAIL kw1_taps: got %0d, required 72", k1_valid_cnt - k1_before);
        end
    endtask

    task automatic test_random_ready();
        int cv, cp, cs, cn;
        for (int i = 0; i < 2; i++) begin
            run_pass(1, -1, 0, -1, cv, cp, cs, cn);
            check_counts("random_ready", cv, cp, cs, cn);
        end
    endtask

    task automatic test_reset_mid();
        int cv, cp, cs, cn;
        run_pass(0, 50, 0, -1, cv, cp, cs, cn);
        run_pass(0, -1, 0, -1, cv, cp, cs, cn);
        check_counts("after_reset", cv, cp, cs, cn);
    endtask

    task automatic test_start_while_busy();
        int cv, cp, cs, cn;
        run_pass(0, -1, 1, -1, cv, cp, cs, cn);
        check_counts("restart_busy", cv, cp, cs, cn);
    endtask

    task automatic test_vg_stall();
        int cv, cp, cs, cn;
        run_pass(0, -1, 0, 14, cv, cp, cs, cn);
        check_counts("vg_stall", cv, cp, cs, cn);
    endtask

    task automatic test_kw1();
        n_tests++;
        if (k1_shift_cnt != 0 || k1_pop_cnt != k1_valid_cnt || k1_valid_cnt == 0) begin
            n_fail++;
            $display("FAIL kw1: shift=%0d pop=%0d valid=%0d, required shift 0, pop==valid>0",
                     k1_shift_cnt, k1_pop_cnt, k1_valid_cnt);
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_full_pass();
        test_random_ready();
        test_reset_mid();
        test_start_while_busy();
        test_vg_stall();
        test_kw1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
